// File: rtl/gru_pkg.sv
// Shared widths, indices and beat layout for the VAD GRU weight streamer.
package gru_pkg;

  localparam int FLOAT   = 32;
  localparam int N_IN    = 24;
  localparam int N_UNITS = 24;
  localparam int N_GATES = 3;
  localparam int WADDR_W = 11;
  localparam int BADDR_W = 7;
  localparam int IDX_W   = 5;
  localparam int BEAT_W  = 3 * FLOAT + 2 * IDX_W + 2;

  typedef enum logic [1:0] {
    GATE_Z = 2'd0,
    GATE_R = 2'd1,
    GATE_H = 2'd2
  } gate_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef struct packed {
    logic [FLOAT-1:0] in_w;
    logic [FLOAT-1:0] rec_w;
    logic [FLOAT-1:0] bias;
    logic [IDX_W-1:0] unit;
    logic [IDX_W-1:0] k;
    logic             first;
    logic             last;
  } beat_t;

  // Keras kernel layout is [k][3*N_UNITS]; the gate picks a column block.
  function automatic logic [WADDR_W-1:0] kernel_addr(input logic [IDX_W-1:0] k,
                                                     input logic [1:0]       g,
                                                     input logic [IDX_W-1:0] j);
    return WADDR_W'(int'(k) * N_GATES * N_UNITS + int'(g) * N_UNITS + int'(j));
  endfunction

  function automatic logic [BADDR_W-1:0] bias_addr(input logic [1:0]       g,
                                                   input logic [IDX_W-1:0] j);
    return BADDR_W'(int'(g) * N_UNITS + int'(j));
  endfunction

endpackage

// File: rtl/gru_rd_skid_fifo.sv
// Fall-through FIFO (depth 1 or 2) holding ROM return beats for the output port.
// Latency: 0 cycles when empty (input appears on output the same cycle), else 1 per entry.
// Backpressure: in_rdy drops only when full and the consumer is stalled.
module gru_rd_skid_fifo #(
  parameter int WIDTH = 108,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_vld,
  output logic             in_rdy,
  input  logic [WIDTH-1:0] in_dat,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [WIDTH-1:0] out_dat
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [CW-1:0]    cnt;
  logic             empty;
  logic             push;
  logic             pop;

  assign empty   = (cnt == '0);
  assign in_rdy  = (cnt != FULL) || out_rdy;
  assign out_vld = !empty || in_vld;
  // Idle output is forced to zero so the port never shows stale ROM data.
  assign out_dat = !empty ? mem[rd_ptr] : (in_vld ? in_dat : '0);
  assign pop     = !empty && out_rdy;
  assign push    = in_vld && in_rdy && !(empty && out_rdy);

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push) begin
        mem[wr_ptr] <= in_dat;
        wr_ptr      <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
      end
      cnt <= cnt + CW'(push) - CW'(pop);
    end
  end

endmodule

// File: rtl/gru_weight_reader.sv
// Streams one GRU gate's (W, U, bias) triples per (unit j, input k), j outer; GRU_RD_SKID_EN selects a 2-deep buffer.
// Latency: start in cycle 0 -> first ROM read cycle 1 -> first m_valid cycle 2.
// Backpressure: reads are credit-gated so every ROM return has a buffer slot; m_ready stalls hold the beat.
module gru_weight_reader
  import gru_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [1:0]         gate_sel,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic               w_rd_en,
  output logic [WADDR_W-1:0] w_addr,
  input  logic [FLOAT-1:0]   in_w_data,
  input  logic [FLOAT-1:0]   rec_w_data,
  output logic [BADDR_W-1:0] b_addr,
  input  logic [FLOAT-1:0]   b_data,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [FLOAT-1:0]   m_in_w,
  output logic [FLOAT-1:0]   m_rec_w,
  output logic [FLOAT-1:0]   m_bias,
  output logic [IDX_W-1:0]   m_unit,
  output logic [IDX_W-1:0]   m_k,
  output logic               m_first,
  output logic               m_last
);

`ifdef GRU_RD_SKID_EN
  localparam int BUF_DEPTH = 2;
`else
  localparam int BUF_DEPTH = 1;
`endif

  localparam logic [1:0]       DEPTH_L = 2'(BUF_DEPTH);
  localparam logic [IDX_W-1:0] K_LAST  = IDX_W'(N_IN - 1);
  localparam logic [IDX_W-1:0] J_LAST  = IDX_W'(N_UNITS - 1);

  state_e           state;
  gate_e            gate_q;
  logic [IDX_W-1:0] nj, nk;
  logic [IDX_W-1:0] iss_j, iss_k;
  logic [IDX_W-1:0] ret_j, ret_k;
  logic             ret_vld;
  logic [1:0]       pend;
  logic [1:0]       pend_left;
  logic             fire;
  logic             issue;
  logic             start_ok;
  logic             fifo_in_rdy;
  beat_t            ret_beat;
  beat_t            out_beat;

  // pend counts beats committed (read issued) but not yet handshaken downstream.
  assign fire      = m_valid && m_ready;
  assign pend_left = pend - {1'b0, fire};
  assign issue     = (state == ST_RUN) && (pend_left < DEPTH_L);
  assign start_ok  = start && (state == ST_IDLE) && (gate_sel < 2'(N_GATES));

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      gate_q  <= GATE_Z;
      nj      <= '0;
      nk      <= '0;
      iss_j   <= '0;
      iss_k   <= '0;
      ret_j   <= '0;
      ret_k   <= '0;
      ret_vld <= 1'b0;
      pend    <= '0;
      w_rd_en <= 1'b0;
      w_addr  <= '0;
      b_addr  <= '0;
      err     <= 1'b0;
    end else begin
      err     <= start && (state == ST_IDLE) && (gate_sel >= 2'(N_GATES));
      ret_vld <= w_rd_en;
      ret_j   <= iss_j;
      ret_k   <= iss_k;
      w_rd_en <= 1'b0;
      pend    <= pend_left;
      case (state)
        ST_IDLE: begin
          if (start_ok) begin
            state   <= ST_RUN;
            gate_q  <= gate_e'(gate_sel);
            w_rd_en <= 1'b1;
            w_addr  <= kernel_addr('0, gate_sel, '0);
            b_addr  <= bias_addr(gate_sel, '0);
            iss_j   <= '0;
            iss_k   <= '0;
            nj      <= '0;
            nk      <= IDX_W'(1);
            pend    <= pend_left + 2'd1;
          end
        end
        ST_RUN: begin
          if (issue) begin
            w_rd_en <= 1'b1;
            w_addr  <= kernel_addr(nk, gate_q, nj);
            b_addr  <= bias_addr(gate_q, nj);
            iss_j   <= nj;
            iss_k   <= nk;
            pend    <= pend_left + 2'd1;
            if (nk == K_LAST) begin
              nk <= '0;
              if (nj == J_LAST) begin
                nj    <= '0;
                state <= ST_DRAIN;
              end else begin
                nj <= nj + 1'b1;
              end
            end else begin
              nk <= nk + 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          if (pend_left == '0) begin
            state <= ST_DONE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // ROM returns cannot be stalled; the credit check guarantees a free slot.
  always_ff @(posedge clk) begin
    if (!rst && ret_vld) begin
      assert (fifo_in_rdy);
    end
  end

  always_comb begin
    ret_beat       = '0;
    ret_beat.in_w  = in_w_data;
    ret_beat.rec_w = rec_w_data;
    ret_beat.bias  = b_data;
    ret_beat.unit  = ret_j;
    ret_beat.k     = ret_k;
    ret_beat.first = (ret_k == '0);
    ret_beat.last  = (ret_k == K_LAST);
  end

  gru_rd_skid_fifo #(
    .WIDTH (BEAT_W),
    .DEPTH (BUF_DEPTH)
  ) u_buf (
    .clk     (clk),
    .rst     (rst),
    .in_vld  (ret_vld),
    .in_rdy  (fifo_in_rdy),
    .in_dat  (ret_beat),
    .out_vld (m_valid),
    .out_rdy (m_ready),
    .out_dat (out_beat)
  );

  assign m_in_w  = out_beat.in_w;
  assign m_rec_w = out_beat.rec_w;
  assign m_bias  = out_beat.bias;
  assign m_unit  = out_beat.unit;
  assign m_k     = out_beat.k;
  assign m_first = out_beat.first;
  assign m_last  = out_beat.last;

endmodule

// File: tb/tb_gru_weight_reader.sv
// Bench for gru_weight_reader: random ROM contents, expected beat order built from the Keras layout.
module tb_gru_weight_reader;
  import gru_pkg::*;

`ifdef GRU_RD_SKID_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif
  localparam int NBEATS = N_IN * N_UNITS;

  typedef struct packed {
    logic [31:0] in_w;
    logic [31:0] rec_w;
    logic [31:0] bias;
    logic [4:0]  unit;
    logic [4:0]  k;
    logic        first;
    logic        last;
  } tbeat_t;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic [1:0]         gate_sel;
  logic               busy, done, err, w_rd_en;
  logic [WADDR_W-1:0] w_addr;
  logic [BADDR_W-1:0] b_addr;
  logic [31:0]        in_w_data, rec_w_data, b_data;
  logic               m_valid, m_ready;
  logic [31:0]        m_in_w, m_rec_w, m_bias;
  logic [4:0]         m_unit, m_k;
  logic               m_first, m_last;

  always #5 clk = ~clk;

  gru_weight_reader dut (
    .clk(clk), .rst(rst), .start(start), .gate_sel(gate_sel),
    .busy(busy), .done(done), .err(err),
    .w_rd_en(w_rd_en), .w_addr(w_addr), .in_w_data(in_w_data), .rec_w_data(rec_w_data),
    .b_addr(b_addr), .b_data(b_data),
    .m_valid(m_valid), .m_ready(m_ready),
    .m_in_w(m_in_w), .m_rec_w(m_rec_w), .m_bias(m_bias),
    .m_unit(m_unit), .m_k(m_k), .m_first(m_first), .m_last(m_last)
  );

  logic [31:0] in_rom  [N_IN*N_GATES*N_UNITS];
  logic [31:0] rec_rom [N_IN*N_GATES*N_UNITS];
  logic [31:0] b_rom   [N_GATES*N_UNITS];

  // Kernel ROM output is garbage except the cycle after a read.
  always @(posedge clk) begin
    if (w_rd_en) begin
      in_w_data  <= in_rom[w_addr];
      rec_w_data <= rec_rom[w_addr];
    end else begin
      in_w_data  <= $urandom;
      rec_w_data <= $urandom;
    end
    b_data <= b_rom[b_addr];
  end

  int n_checks = 0;
  int n_fail   = 0;

  tbeat_t exp_q[$];
  tbeat_t got[$];
  int     got_cyc[$];
  int     done_cnt, done_cyc, err_cnt, err_cyc, rd_cnt, rd_early, busy_cnt, stab_bad;

  function automatic void build_exp(input int g);
    tbeat_t e;
    exp_q.delete();
    for (int j = 0; j < N_UNITS; j++) begin
      for (int k = 0; k < N_IN; k++) begin
        e.in_w  = in_rom[k*N_GATES*N_UNITS + g*N_UNITS + j];
        e.rec_w = rec_rom[k*N_GATES*N_UNITS + g*N_UNITS + j];
        e.bias  = b_rom[g*N_UNITS + j];
        e.unit  = 5'(j);
        e.k     = 5'(k);
        e.first = (k == 0);
        e.last  = (k == N_IN - 1);
        exp_q.push_back(e);
      end
    end
  endfunction

  function automatic int count_bad();
    int nbad = 0;
    for (int i = 0; i < NBEATS; i++) begin
      if (i >= got.size() || got[i] !== exp_q[i]) nbad++;
    end
    return nbad;
  endfunction

  function automatic logic ready_for(input int mode, input int c);
    case (mode)
      1:       return (c % 2 == 0);
      2:       return ($urandom_range(0, 3) != 0);
      3:       return (c > 50);
      default: return 1'b1;
    endcase
  endfunction

  // Pulses start at cycle 0 and records observations cycle by cycle until done+5 or budget.
  task automatic run(input logic [1:0] g, input int mode, input int budget,
                     input int rst_beat, input int restart_beat);
    tbeat_t cur, prev;
    logic   prev_stall;
    int     tail;
    got.delete(); got_cyc.delete();
    done_cnt = 0; done_cyc = -1; err_cnt = 0; err_cyc = -1;
    rd_cnt = 0; rd_early = 0; busy_cnt = 0; stab_bad = 0;
    prev_stall = 1'b0; prev = '0; tail = -1;
    @(negedge clk);
    start = 1'b1; gate_sel = g; m_ready = ready_for(mode, 0);
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk);
      start   = 1'b0;
      m_ready = ready_for(mode, c);
      if (restart_beat >= 0 && got.size() == restart_beat) begin
        start = 1'b1; gate_sel = 2'd1;
      end
      cur = {m_in_w, m_rec_w, m_bias, m_unit, m_k, m_first, m_last};
      if (w_rd_en) begin rd_cnt++; if (c <= 50) rd_early++; end
      if (busy) busy_cnt++;
      if (err) begin err_cnt++; if (err_cyc < 0) err_cyc = c; end
      if (done) begin done_cnt++; if (done_cyc < 0) done_cyc = c; end
      if (prev_stall && (!m_valid || cur !== prev)) stab_bad++;
      prev_stall = m_valid && !m_ready;
      prev = cur;
      if (m_valid && m_ready) begin got.push_back(cur); got_cyc.push_back(c); end
      if (rst_beat >= 0 && got.size() == rst_beat) begin rst = 1'b1; break; end
      if (done && tail < 0) tail = 5;
      else if (tail > 0) tail--;
      if (tail == 0) break;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; gate_sel = 2'd0; m_ready = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({busy, done, err, w_rd_en, m_valid, m_first, m_last} !== 7'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b required 0000000", {busy, done, err, w_rd_en, m_valid, m_first, m_last});
    end
    n_checks++;
    if ({w_addr, b_addr, m_unit, m_k} !== '0) begin
      n_fail++; $display("FAIL reset_addr: w_addr %0d b_addr %0d unit %0d k %0d required all 0", w_addr, b_addr, m_unit, m_k);
    end
    n_checks++;
    if ({m_in_w, m_rec_w, m_bias} !== '0) begin
      n_fail++; $display("FAIL reset_data: got %h %h %h required 0", m_in_w, m_rec_w, m_bias);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_gate1_full();
    int last_cyc;
    build_exp(1);
    run(2'd1, 0, 3000, -1, -1);
    last_cyc = 2 + (NBEATS - 1) * ((DEPTH == 2) ? 1 : 2);
    n_checks++;
    if (got.size() !== NBEATS) begin
      n_fail++; $display("FAIL g1_count: got %0d beats required %0d", got.size(), NBEATS);
    end
    if (got.size() == NBEATS) begin
      n_checks++;
      if (got[0].in_w !== in_rom[24] || got[0].unit !== 5'd0 || got[0].first !== 1'b1) begin
        n_fail++; $display("FAIL g1_beat0: in_w %h unit %0d first %b required %h 0 1", got[0].in_w, got[0].unit, got[0].first, in_rom[24]);
      end
      n_checks++;
      if (got[1].in_w !== in_rom[96]) begin
        n_fail++; $display("FAIL g1_beat1: in_w %h required %h", got[1].in_w, in_rom[96]);
      end
      n_checks++;
      if (got[575].in_w !== in_rom[1703] || got[575].unit !== 5'd23 || got[575].k !== 5'd23 || got[575].last !== 1'b1) begin
        n_fail++; $display("FAIL g1_beat575: in_w %h unit %0d k %0d last %b required %h 23 23 1", got[575].in_w, got[575].unit, got[575].k, got[575].last, in_rom[1703]);
      end
      n_checks++;
      if (got_cyc[0] !== 2) begin
        n_fail++; $display("FAIL g1_first_cycle: got %0d required 2", got_cyc[0]);
      end
      n_checks++;
      if (got_cyc[NBEATS-1] !== last_cyc) begin
        n_fail++; $display("FAIL g1_last_cycle: got %0d required %0d", got_cyc[NBEATS-1], last_cyc);
      end
    end
    n_checks++;
    if (count_bad() !== 0) begin
      n_fail++; $display("FAIL g1_stream: %0d beats differ from model, required 0", count_bad());
    end
    n_checks++;
    if (done_cnt !== 1 || done_cyc !== last_cyc + 1) begin
      n_fail++; $display("FAIL g1_done: %0d pulses at cycle %0d required 1 at %0d", done_cnt, done_cyc, last_cyc + 1);
    end
    n_checks++;
    if (rd_cnt !== NBEATS) begin
      n_fail++; $display("FAIL g1_reads: got %0d required %0d", rd_cnt, NBEATS);
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL g1_busy_after: got %b required 0", busy);
    end
  endtask

  task automatic test_stall(input int mode);
    build_exp(2);
    run(2'd2, mode, 6000, -1, -1);
    n_checks++;
    if (got.size() !== NBEATS || count_bad() !== 0) begin
      n_fail++; $display("FAIL stall_stream_m%0d: %0d beats, %0d differ; required %0d beats, 0 differ", mode, got.size(), count_bad(), NBEATS);
    end
    n_checks++;
    if (stab_bad !== 0) begin
      n_fail++; $display("FAIL stall_stable_m%0d: %0d unstable stall cycles required 0", mode, stab_bad);
    end
    n_checks++;
    if (done_cnt !== 1) begin
      n_fail++; $display("FAIL stall_done_m%0d: got %0d pulses required 1", mode, done_cnt);
    end
  endtask

  task automatic test_bad_gate();
    run(2'd3, 0, 12, -1, -1);
    n_checks++;
    if (err_cnt !== 1 || err_cyc !== 1) begin
      n_fail++; $display("FAIL bad_gate_err: %0d pulses first at %0d required 1 at cycle 1", err_cnt, err_cyc);
    end
    n_checks++;
    if (busy_cnt !== 0 || rd_cnt !== 0 || got.size() !== 0 || done_cnt !== 0) begin
      n_fail++; $display("FAIL bad_gate_idle: busy %0d reads %0d beats %0d done %0d required all 0", busy_cnt, rd_cnt, got.size(), done_cnt);
    end
  endtask

  task automatic test_double_start();
    build_exp(0);
    run(2'd0, 0, 3000, -1, 100);
    n_checks++;
    if (got.size() !== NBEATS || count_bad() !== 0) begin
      n_fail++; $display("FAIL dbl_stream: %0d beats, %0d differ; required %0d, 0", got.size(), count_bad(), NBEATS);
    end
    n_checks++;
    if (done_cnt !== 1 || err_cnt !== 0) begin
      n_fail++; $display("FAIL dbl_done_err: done %0d err %0d required 1 0", done_cnt, err_cnt);
    end
  endtask

  task automatic test_mid_reset();
    build_exp(0);
    run(2'd0, 0, 3000, 300, -1);
    @(negedge clk);
    n_checks++;
    if (got.size() !== 300 || m_valid !== 1'b0 || busy !== 1'b0 || w_rd_en !== 1'b0) begin
      n_fail++; $display("FAIL midrst_abort: beats %0d valid %b busy %b rd_en %b required 300 0 0 0", got.size(), m_valid, busy, w_rd_en);
    end
    rst = 1'b0;
    run(2'd0, 0, 3000, -1, -1);
    n_checks++;
    if (got.size() !== NBEATS || count_bad() !== 0 || done_cnt !== 1) begin
      n_fail++; $display("FAIL midrst_restart: %0d beats, %0d differ, %0d done; required %0d, 0, 1", got.size(), count_bad(), done_cnt, NBEATS);
    end
  endtask

  task automatic test_initial_stall();
    build_exp(0);
    run(2'd0, 3, 3000, -1, -1);
    n_checks++;
    if (rd_early > DEPTH || rd_early == 0) begin
      n_fail++; $display("FAIL hold_reads: %0d reads during stall required 1..%0d", rd_early, DEPTH);
    end
    n_checks++;
    if (got.size() !== NBEATS || count_bad() !== 0 || done_cnt !== 1) begin
      n_fail++; $display("FAIL hold_stream: %0d beats, %0d differ, %0d done; required %0d, 0, 1", got.size(), count_bad(), done_cnt, NBEATS);
    end
  endtask

  initial begin
    for (int i = 0; i < N_IN*N_GATES*N_UNITS; i++) begin
      in_rom[i]  = $urandom;
      rec_rom[i] = $urandom;
    end
    for (int i = 0; i < N_GATES*N_UNITS; i++) b_rom[i] = $urandom;
    test_reset();
    test_gate1_full();
    test_stall(1);
    test_stall(2);
    test_bad_gate();
    test_double_start();
    test_mid_reset();
    test_initial_stall();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
